// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one SRAM-like port between inst and data requesters,
// tracking in-order responses in an ID FIFO. Optional macro: ARB_ROUND_ROBIN_EN.
`default_nettype none

module sram_req_arbiter #(
  parameter int OUTSTANDING = 2,
  parameter int PTR_W       = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        arb_err
);

  localparam int               LAST_I   = OUTSTANDING - 1;
  localparam logic [PTR_W-1:0] LAST_PTR = LAST_I[PTR_W-1:0];
  localparam logic [PTR_W:0]   FULL_CNT = OUTSTANDING[PTR_W:0];

  logic [OUTSTANDING-1:0] id_fifo;
  logic [PTR_W-1:0]       wptr;
  logic [PTR_W-1:0]       rptr;
  logic [PTR_W:0]         count;
  logic [PTR_W:0]         count_nxt;
  logic                   lock;
  logic                   lock_id;
  logic                   err;
  logic                   sel;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic                   head;

  assign full = (count == FULL_CNT);
  assign pop  = mem_data_ok & (count != '0);
  assign head = id_fifo[rptr];

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  // Under contention, alternate away from whoever was granted last.
  always_comb begin
    sel = data_req;
    if (lock) begin
      sel = lock_id;
    end else if (inst_req & data_req) begin
      sel = ~last_grant;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b0;
    end else if (push) begin
      last_grant <= sel;
    end
  end
`else
  always_comb begin
    sel = lock ? lock_id : data_req;
  end
`endif

  assign mem_req = (inst_req | data_req) & ~full;
  assign push    = mem_req & mem_addr_ok;

  always_comb begin
    mem_wr    = inst_wr;
    mem_size  = inst_size;
    mem_wstrb = inst_wstrb;
    mem_addr  = inst_addr;
    mem_wdata = inst_wdata;
    if (sel) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end
  end

  assign inst_addr_ok = push & ~sel;
  assign data_addr_ok = push & sel;
  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop & head;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign arb_err      = err;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_fifo <= '0;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      lock    <= 1'b0;
      lock_id <= 1'b0;
      err     <= 1'b0;
    end else begin
      count <= count_nxt;
      if (push) begin
        id_fifo[wptr] <= sel;
        wptr          <= (wptr == LAST_PTR) ? '0 : wptr + 1'b1;
      end
      if (pop) begin
        rptr <= (rptr == LAST_PTR) ? '0 : rptr + 1'b1;
      end
      // A held request pins the selection until memory accepts it; a stall
      // on full leaves mem_req low, so the lock simply carries over.
      if (mem_req) begin
        lock    <= ~mem_addr_ok;
        lock_id <= sel;
      end
      if (mem_data_ok & (count == '0)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_req_arbiter.sv
// tb_sram_req_arbiter: directed plan steps plus randomized traffic, checked
// against a queue-based transaction model of the arbiter.
`default_nettype none

module tb_sram_req_arbiter;

  localparam int OUT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        arb_err;

  sram_req_arbiter #(.OUTSTANDING(OUT), .PTR_W(1)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Transaction-level model: queue of requester ids awaiting responses,
  // which requester (if any) has a presented-but-unaccepted request, error flag.
  bit q[$];
  bit m_lock = 1'b0;
  bit m_lockid = 1'b0;
  bit m_err = 1'b0;
  bit m_last = 1'b0;
  bit e_iaok, e_daok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit any, full, owner, mreq, acc, pop, head, was_empty;
    #1;
    any       = inst_req | data_req;
    full      = (q.size() == OUT);
    was_empty = (q.size() == 0);
    if (m_lock) owner = m_lockid;
`ifdef ARB_ROUND_ROBIN_EN
    else if (inst_req && data_req) owner = ~m_last;
`endif
    else owner = data_req;
    mreq   = any & !full;
    acc    = mreq & mem_addr_ok;
    pop    = mem_data_ok & !was_empty;
    head   = 1'b0;
    if (pop) head = q[0];
    e_iaok = acc & !owner;
    e_daok = acc & owner;
    if (!reset) begin
      chk("mem_req", mem_req, mreq);
      if (mreq) begin
        chk("mem_addr",  mem_addr,  owner ? data_addr  : inst_addr);
        chk("mem_wdata", mem_wdata, owner ? data_wdata : inst_wdata);
        chk("mem_wr",    mem_wr,    owner ? data_wr    : inst_wr);
        chk("mem_size",  mem_size,  owner ? data_size  : inst_size);
        chk("mem_wstrb", mem_wstrb, owner ? data_wstrb : inst_wstrb);
      end
      chk("inst_addr_ok", inst_addr_ok, e_iaok);
      chk("data_addr_ok", data_addr_ok, e_daok);
      chk("inst_data_ok", inst_data_ok, pop & !head);
      chk("data_data_ok", data_data_ok, pop & head);
      chk("arb_err", arb_err, m_err);
      if (pop && !head) chk("inst_rdata", inst_rdata, mem_rdata);
      if (pop && head)  chk("data_rdata", data_rdata, mem_rdata);
    end
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_lock = 1'b0; m_lockid = 1'b0; m_err = 1'b0; m_last = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin q.push_back(owner); m_last = owner; end
      if (mreq) begin m_lock = !mem_addr_ok; m_lockid = owner; end
      if (mem_data_ok && was_empty) m_err = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      mem_data_ok = 1'b1; mem_rdata = $urandom;
      step();
    end
    mem_data_ok = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    @(negedge clk);
    step();
    reset = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_arb_err", arb_err, 0);
    step();

    // 1: single read
    inst_req = 1; inst_addr = 32'h1C00_0000; inst_size = 2; mem_addr_ok = 1;
    #1 chk("t1_inst_addr_ok", inst_addr_ok, 1);
    step();
    inst_req = 0; mem_addr_ok = 0;
    step();
    mem_data_ok = 1; mem_rdata = 32'h0280_0C0C;
    #1;
    chk("t1_inst_data_ok", inst_data_ok, 1);
    chk("t1_inst_rdata", inst_rdata, 32'h0280_0C0C);
    chk("t1_data_data_ok", data_data_ok, 0);
    step();
    mem_data_ok = 0;

    // 2: contention, data first then inst; responses in order
    inst_req = 1; inst_addr = 32'h1C00_0004;
    data_req = 1; data_wr = 1; data_addr = 32'h1C00_8000; data_wstrb = 4'hF;
    data_size = 2; data_wdata = 32'hDEAD_BEEF; mem_addr_ok = 1;
    #1 chk("t2_data_first", data_addr_ok, 1);
    step();
    data_req = 0;
    #1 chk("t2_inst_second", inst_addr_ok, 1);
    step();
    inst_req = 0; mem_addr_ok = 0;
    mem_data_ok = 1; mem_rdata = 32'hAAAA_0001;
    #1 chk("t2_resp_a_data", data_data_ok, 1);
    step();
    mem_rdata = 32'hBBBB_0002;
    #1 chk("t2_resp_b_inst", inst_data_ok, 1);
    step();
    mem_data_ok = 0;

    // 3: lock holds data fields while inst arrives
    data_req = 1; data_wr = 0; data_addr = 32'h1C00_8010; mem_addr_ok = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t3_hold_addr", mem_addr, 32'h1C00_8010);
      step();
    end
    inst_req = 1; inst_addr = 32'h1C00_0020;
    #1 chk("t3_locked_addr", mem_addr, 32'h1C00_8010);
    step();
    mem_addr_ok = 1;
    #1 chk("t3_data_acc", data_addr_ok, 1);
    step();
    data_req = 0;
    #1 chk("t3_inst_acc", inst_addr_ok, 1);
    step();
    drain();

    // 4: full blocks issue; a pop unblocks only next cycle
    data_req = 1; data_addr = 32'h1C00_9000; mem_addr_ok = 1;
    step();
    data_req = 0; inst_req = 1; inst_addr = 32'h1C00_0040;
    step();
    inst_addr = 32'h1C00_0044;
    #1 chk("t4_full_blocks", mem_req, 0);
    step();
    mem_data_ok = 1; mem_rdata = 32'h1111_2222;
    #1 chk("t4_pop_same_cycle", mem_req, 0);
    step();
    mem_data_ok = 0;
    #1 chk("t4_reissue", mem_req, 1);
    step();
    for (int i = 0; i < 10; i++) begin
      inst_req = 1; inst_addr = 32'h1C00_0100 + 32'(i * 4); mem_addr_ok = 1;
      mem_data_ok = 1; mem_rdata = $urandom;
      step();
    end
    drain();

    // randomized traffic; requests are held until the model says accepted
    for (int c = 0; c < 400; c++) begin
      if (e_iaok) inst_req = 0;
      if (e_daok) data_req = 0;
      if (!inst_req && ($urandom_range(0, 2) == 0)) begin
        inst_req = 1; inst_wr = 1'($urandom); inst_size = 2'($urandom_range(0, 2));
        inst_wstrb = 4'($urandom); inst_addr = $urandom; inst_wdata = $urandom;
      end
      if (!data_req && ($urandom_range(0, 2) == 0)) begin
        data_req = 1; data_wr = 1'($urandom); data_size = 2'($urandom_range(0, 2));
        data_wstrb = 4'($urandom); data_addr = $urandom; data_wdata = $urandom;
      end
      mem_addr_ok = 1'($urandom);
      mem_data_ok = (q.size() > 0) && ($urandom_range(0, 4) < 2);
      mem_rdata   = $urandom;
      step();
    end
    if (e_iaok) inst_req = 0;
    if (e_daok) data_req = 0;
    mem_addr_ok = 1;
    for (int k = 0; k < 10 && (inst_req || data_req); k++) begin
      mem_data_ok = (q.size() > 0);
      step();
      if (e_iaok) inst_req = 0;
      if (e_daok) data_req = 0;
    end
    drain();

    // 5: response with empty FIFO, then reset mid-transaction
    mem_data_ok = 1; mem_rdata = 32'h5555_5555;
    #1;
    chk("t5_no_inst_ok", inst_data_ok, 0);
    chk("t5_no_data_ok", data_data_ok, 0);
    step();
    mem_data_ok = 0;
    #1 chk("t5_arb_err", arb_err, 1);
    step();
    inst_req = 1; inst_addr = 32'h1C00_0200; mem_addr_ok = 1;
    step();
    inst_req = 0; data_req = 1; data_addr = 32'h1C00_A000; mem_addr_ok = 0;
    step();
    data_req = 0; reset = 1;
    step();
    reset = 0;
    #1;
    chk("t5_rst_arb_err", arb_err, 0);
    chk("t5_rst_mem_req", mem_req, 0);
    step();
    inst_req = 1; inst_addr = 32'h1C00_0300; mem_addr_ok = 1;
    #1 chk("t5_post_rst_inst_acc", inst_addr_ok, 1);
    step();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h0BAD_F00D;
    #1 chk("t5_post_rst_resp", inst_data_ok, 1);
    step();
    mem_data_ok = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
